// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store memory master.
// Size codes, memory strobe codes, FSM states, strobe encoder.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      WR,
      RESP
   } state_e;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B0   = 4'b0001;
   localparam logic [3:0] STRB_B1   = 4'b0010;
   localparam logic [3:0] STRB_B2   = 4'b0011;
   localparam logic [3:0] STRB_B3   = 4'b0100;
   localparam logic [3:0] STRB_HLO  = 4'b0101;
   localparam logic [3:0] STRB_HHI  = 4'b0110;
   localparam logic [3:0] STRB_WORD = 4'b0111;

   function automatic logic [3:0] strb_code(
      input size_e      size,
      input logic [1:0] lo
   );
      logic [3:0] s;
      s = STRB_NONE;
      case (size)
         SZ_BYTE: begin
            case (lo)
               2'd0:    s = STRB_B0;
               2'd1:    s = STRB_B1;
               2'd2:    s = STRB_B2;
               default: s = STRB_B3;
            endcase
         end
         SZ_HALF: s = lo[1] ? STRB_HHI : STRB_HLO;
         SZ_WORD: s = STRB_WORD;
         default: s = STRB_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half lane of a read word
// and sign- or zero-extends it; words pass through unchanged.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] word,
   input  size_e            size,
   input  logic [1:0]       lo,
   input  logic             uns,
   output logic [WIDTH-1:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   // Lane select followed by extension from bit 7 or bit 15.
   always_comb begin
      b    = word[{lo, 3'b000} +: 8];
      h    = word[{lo[1], 4'b0000} +: 16];
      data = '0;
      case (size)
         SZ_BYTE: data = {{(WIDTH-8){b[7] & ~uns}}, b};
         SZ_HALF: data = {{(WIDTH-16){h[15] & ~uns}}, h};
         SZ_WORD: data = word;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for data_memory.
// LSU_MISALIGN_TRAP_EN: misaligned half/word become errors instead of being aligned.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 128,
   parameter int RD_LAT = 1,
   parameter int ADDR_W = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WIDTH-1:0]  resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-3:0] mem_rd_addr0,
   output logic [ADDR_W-3:0] mem_wr_addr0,
   output logic [WIDTH-1:0]  mem_wr_din0,
   output logic [3:0]        mem_wr_strb,
   output logic              mem_we0,
   input  logic [WIDTH-1:0]  mem_rd_dout0
);

   state_e           state;
   size_e            sz_q;
   logic             uns_q;
   logic [1:0]       lo_q;
   logic [2:0]       cnt;
   size_e            req_sz;
   logic [1:0]       req_lo;
   logic             req_bad;
   logic [WIDTH-1:0] wmask;
   logic [WIDTH-1:0] ld_data;

   assign req_sz = size_e'(req_size);

   // Classify the incoming request: lane bits, error flag, store mask.
   always_comb begin
      req_lo  = req_addr[1:0];
      req_bad = (req_sz == SZ_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
      if (req_sz == SZ_HALF && req_addr[0])
         req_bad = 1'b1;
      if (req_sz == SZ_WORD && req_addr[1:0] != 2'b00)
         req_bad = 1'b1;
`else
      if (req_sz == SZ_HALF)
         req_lo[0] = 1'b0;
      if (req_sz == SZ_WORD)
         req_lo = 2'b00;
`endif
      case (req_sz)
         SZ_BYTE: wmask = WIDTH'(32'h0000_00ff);
         SZ_HALF: wmask = WIDTH'(32'h0000_ffff);
         default: wmask = '1;
      endcase
   end

   lsu_load_align #(
      .WIDTH (WIDTH)
   ) u_align (
      .word (mem_rd_dout0),
      .size (sz_q),
      .lo   (lo_q),
      .uns  (uns_q),
      .data (ld_data)
   );

   // Request/response FSM; every output is registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_err     <= 1'b0;
         mem_rd_addr0 <= '0;
         mem_wr_addr0 <= '0;
         mem_wr_din0  <= '0;
         mem_wr_strb  <= STRB_NONE;
         mem_we0      <= 1'b0;
         sz_q         <= SZ_BYTE;
         uns_q        <= 1'b0;
         lo_q         <= 2'b00;
         cnt          <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  sz_q      <= req_sz;
                  uns_q     <= req_unsigned;
                  lo_q      <= req_lo;
                  if (req_bad) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (req_we) begin
                     state        <= WR;
                     mem_we0      <= 1'b1;
                     mem_wr_addr0 <= req_addr[ADDR_W-1:2];
                     mem_wr_din0  <= req_wdata & wmask;
                     mem_wr_strb  <= strb_code(req_sz, req_lo);
                  end else begin
                     state        <= RD_WAIT;
                     mem_rd_addr0 <= req_addr[ADDR_W-1:2];
                     cnt          <= 3'(RD_LAT);
                  end
               end
            end
            RD_WAIT: begin
               if (cnt == 3'd0) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= ld_data;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            WR: begin
               state       <= RESP;
               mem_we0     <= 1'b0;
               mem_wr_strb <= STRB_NONE;
               resp_valid  <= 1'b1;
               resp_err    <= 1'b0;
               resp_rdata  <= '0;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed bench with a byte-array reference model,
// a latency-modelled memory and a per-cycle output monitor.
module tb_lsu_mem_master;

   localparam int LAT = 2;
   localparam int AW  = 9;
   localparam logic [1:0] B = 2'd0;
   localparam logic [1:0] H = 2'd1;
   localparam logic [1:0] W = 2'd2;
   localparam logic [1:0] R = 2'd3;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [6:0]    mem_rd_addr0;
   logic [6:0]    mem_wr_addr0;
   logic [31:0]   mem_wr_din0;
   logic [3:0]    mem_wr_strb;
   logic          mem_we0;
   logic [31:0]   mem_rd_dout0;

   lsu_mem_master #(
      .WIDTH  (32),
      .DEPTH  (128),
      .RD_LAT (LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_rd_addr0 (mem_rd_addr0),
      .mem_wr_addr0 (mem_wr_addr0),
      .mem_wr_din0  (mem_wr_din0),
      .mem_wr_strb  (mem_wr_strb),
      .mem_we0      (mem_we0),
      .mem_rd_dout0 (mem_rd_dout0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Memory: strobe-decoded writes, reads delayed LAT cycles.
   logic [31:0] ram  [128];
   logic [6:0]  pipe [LAT];
   logic        clr;

   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= mem_rd_addr0;
      if (clr) begin
         for (int i = 0; i < 128; i++) ram[i] <= '0;
      end else if (mem_we0) begin
         case (mem_wr_strb)
            4'b0001: ram[mem_wr_addr0][7:0]   <= mem_wr_din0[7:0];
            4'b0010: ram[mem_wr_addr0][15:8]  <= mem_wr_din0[7:0];
            4'b0011: ram[mem_wr_addr0][23:16] <= mem_wr_din0[7:0];
            4'b0100: ram[mem_wr_addr0][31:24] <= mem_wr_din0[7:0];
            4'b0101: ram[mem_wr_addr0][15:0]  <= mem_wr_din0[15:0];
            4'b0110: ram[mem_wr_addr0][31:16] <= mem_wr_din0[15:0];
            4'b0111: ram[mem_wr_addr0]        <= mem_wr_din0;
            default: ;
         endcase
      end
   end

   assign mem_rd_dout0 = ram[pipe[LAT-1]];

   // Reference model: byte-addressed memory and expected traffic.
   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   typedef struct {
      logic [6:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
   } wr_t;

   resp_t      rq[$];
   wr_t        wq[$];
   logic [7:0] refm [512];

   task automatic model(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [8:0] addr,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
      int          n;
      int          ea;
      logic [63:0] mask;
      logic [63:0] v;
      resp_t       r;
      wr_t         w;
      n  = 1 << sz;
      ea = int'(addr);
      er = (sz == R);
      rd = '0;
      if (!er && (ea % n) != 0) begin
         if (TRAP) er = 1'b1;
         else ea = ea - (ea % n);
      end
      if (!er) begin
         mask = (64'd1 << (8 * n)) - 64'd1;
         if (we) begin
            for (int i = 0; i < n; i++) refm[ea+i] = wd[8*i +: 8];
            w.a = 7'(ea / 4);
            w.d = wd & mask[31:0];
            if (sz == B) w.s = 4'(1 + ea % 4);
            else if (sz == H) w.s = 4'(5 + (ea % 4) / 2);
            else w.s = 4'd7;
            wq.push_back(w);
         end else begin
            v = '0;
            for (int i = 0; i < n; i++)
               v = v | (64'(refm[ea+i]) << (8 * i));
            if (!uns && v[8*n-1]) v = v | ~mask;
            rd = v[31:0];
         end
      end
      r.rdata = rd;
      r.err   = er;
      rq.push_back(r);
   endtask

   // Monitor: compares memory writes and responses every cycle.
   always @(negedge clk) begin
      wr_t w;
      if (rst && !clr) begin
         if (mem_we0) begin
            if (wq.size() == 0) begin
               check("spurious_we0", 32'(mem_we0), 32'd0);
            end else begin
               w = wq.pop_front();
               check("wr_addr", 32'(mem_wr_addr0), 32'(w.a));
               check("wr_din", mem_wr_din0, w.d);
               check("wr_strb", 32'(mem_wr_strb), 32'(w.s));
            end
         end else begin
            check("strb_idle", 32'(mem_wr_strb), 32'd0);
         end
         if (resp_valid) begin
            if (rq.size() == 0) begin
               check("spurious_resp", 32'(resp_valid), 32'd0);
            end else begin
               check("mon_rdata", resp_rdata, rq[0].rdata);
               check("mon_err", 32'(resp_err), 32'(rq[0].err));
               if (resp_ready) void'(rq.pop_front());
            end
         end
      end
   end

   task automatic wait_ready();
      int k;
      k = 0;
      while (!req_ready && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("req_ready_seen", 32'(req_ready), 32'd1);
   endtask

   task automatic req(input logic we, input logic [1:0] sz,
                      input logic uns, input logic [8:0] addr,
                      input logic [31:0] wd, input logic [31:0] lit,
                      input int stall);
      logic [31:0] erd;
      logic        eer;
      int          n;
      int          lat;
      model(we, sz, uns, addr, wd, erd, eer);
      check("model_vs_literal", erd, lit);
      @(posedge clk);
      #1;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      resp_ready   = (stall == 0);
      wait_ready();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 40);
      lat = eer ? 1 : (we ? 2 : LAT + 2);
      check("latency", 32'(n), 32'(lat));
      check("resp_rdata", resp_rdata, lit);
      check("resp_err", 32'(resp_err), 32'(eer));
      repeat (stall) begin
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      if (stall > 0) begin
         @(posedge clk);
         #1;
         resp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("resp_released", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 512; i++) refm[i] = 8'h00;
      rst          = 1'b0;
      clr          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = W;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      resp_ready   = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_rd_addr", 32'(mem_rd_addr0), 32'd0);
      check("rst_wr_addr", 32'(mem_wr_addr0), 32'd0);
      check("rst_wr_din", mem_wr_din0, 32'd0);
      check("rst_wr_strb", 32'(mem_wr_strb), 32'd0);
      check("rst_we0", 32'(mem_we0), 32'd0);
      clr = 1'b0;
      rst = 1'b1;

      req(1'b1, W, 1'b0, 9'h00, 32'h12345678, 32'h0, 0);
      req(1'b0, W, 1'b0, 9'h00, 32'h0, 32'h12345678, 0);
      req(1'b1, B, 1'b0, 9'h04, 32'hffffffaa, 32'h0, 0);
      req(1'b1, B, 1'b0, 9'h05, 32'h123456bb, 32'h0, 0);
      req(1'b1, B, 1'b0, 9'h06, 32'h000000cc, 32'h0, 0);
      req(1'b1, B, 1'b0, 9'h07, 32'h000000dd, 32'h0, 0);
      req(1'b0, W, 1'b0, 9'h04, 32'h0, 32'hddccbbaa, 0);
      req(1'b0, B, 1'b0, 9'h07, 32'h0, 32'hffffffdd, 0);
      req(1'b0, B, 1'b1, 9'h07, 32'h0, 32'h000000dd, 0);
      req(1'b0, H, 1'b0, 9'h06, 32'h0, 32'hffffddcc, 0);
      req(1'b0, H, 1'b1, 9'h04, 32'h0, 32'h0000bbaa, 0);
      req(1'b0, B, 1'b0, 9'h05, 32'h0, 32'hffffffbb, 0);
      req(1'b1, H, 1'b0, 9'h08, 32'hffff1234, 32'h0, 0);
      req(1'b1, H, 1'b0, 9'h0a, 32'h00005678, 32'h0, 0);
      req(1'b0, W, 1'b0, 9'h08, 32'h0, 32'h56781234, 0);
      req(1'b0, B, 1'b1, 9'h09, 32'h0, 32'h00000012, 0);
      req(1'b0, H, 1'b0, 9'h0a, 32'h0, 32'h00005678, 0);
      req(1'b0, W, 1'b0, 9'h02, 32'h0,
          TRAP ? 32'h0 : 32'h12345678, 0);
      req(1'b0, R, 1'b0, 9'h00, 32'h0, 32'h0, 0);
      req(1'b0, W, 1'b0, 9'h04, 32'h0, 32'hddccbbaa, 5);

      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = W;
      req_addr  = 9'h04;
      wait_ready();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rd_addr_driven", 32'(mem_rd_addr0), 32'd1);
      rst = 1'b0;
      #1;
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd0);
      check("abort_rd_addr", 32'(mem_rd_addr0), 32'd0);
      check("abort_we0", 32'(mem_we0), 32'd0);
      check("abort_rdata", resp_rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      begin
         int k;
         k = 0;
         while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
         end
      end
      check("ready_after_reset", 32'(req_ready), 32'd1);
      repeat (LAT + 4) begin
         @(negedge clk);
         check("no_resp_after_abort", 32'(resp_valid), 32'd0);
      end

      req(1'b0, W, 1'b0, 9'h08, 32'h0, 32'h56781234, 0);
      req(1'b1, H, 1'b0, 9'h0d, 32'h0000beef, 32'h0, 0);
      req(1'b0, H, 1'b0, 9'h0c, 32'h0,
          TRAP ? 32'h0 : 32'hffffbeef, 0);

      repeat (3) @(negedge clk);
      check("wq_drained", 32'(wq.size()), 32'd0);
      check("rq_drained", 32'(rq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
